// File: rtl/change_dispenser.sv
// Greedy change dispenser: pays out a latched amount one coin per cycle, largest denomination first.
// Optional CHANGE_STATS_EN adds saturating coins-paid and short-payout counters.
module change_dispenser #(
    parameter logic [31:0] COIN0_VAL = 32'd100,
    parameter logic [31:0] COIN1_VAL = 32'd500,
    parameter logic [31:0] COIN2_VAL = 32'd1000,
    parameter int          CNT_W     = 8,
    parameter int unsigned INIT_CNT  = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_return_req,
    input  logic [31:0]          i_return_total,
    input  logic                 i_refill,
    input  logic [2:0]           i_refill_coin,
    output logic [2:0]           o_return_coin,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [31:0]          o_remainder,
    output logic [3*CNT_W-1:0]   o_inv_cnt
`ifdef CHANGE_STATS_EN
    ,
    output logic [15:0]          o_coins_paid,
    output logic [7:0]           o_short_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        DONE     = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] INIT_C  = CNT_W'(INIT_CNT);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    state_t             state_r, state_s;
    logic [31:0]        remaining_r, remaining_s;
    logic [CNT_W-1:0]   inv_r [3];
    logic [CNT_W-1:0]   inv_s [3];
    logic [2:0]         fit_s;
    logic [2:0]         pick_s;
    logic [2:0]         coin_s;
    logic [31:0]        remainder_s;
    logic               busy_s;
    logic               done_s;

    // Highest-value fitting coin wins; result is one-hot or zero.
    function automatic logic [2:0] pick_coin(input logic [2:0] fit);
        logic [2:0] sel;
        if (fit[2]) begin
            sel = 3'b100;
        end else if (fit[1]) begin
            sel = 3'b010;
        end else if (fit[0]) begin
            sel = 3'b001;
        end else begin
            sel = 3'b000;
        end
        return sel;
    endfunction

    function automatic logic [31:0] coin_value(input logic [2:0] onehot);
        logic [31:0] val;
        case (onehot)
            3'b001:  val = COIN0_VAL;
            3'b010:  val = COIN1_VAL;
            3'b100:  val = COIN2_VAL;
            default: val = 32'd0;
        endcase
        return val;
    endfunction

    // Next-state, payout selection and inventory update.
    always_comb begin
        state_s     = state_r;
        remaining_s = remaining_r;
        inv_s       = inv_r;
        coin_s      = 3'b000;
        remainder_s = o_remainder;
        fit_s[0]    = (remaining_r >= COIN0_VAL) && (inv_r[0] != '0);
        fit_s[1]    = (remaining_r >= COIN1_VAL) && (inv_r[1] != '0);
        fit_s[2]    = (remaining_r >= COIN2_VAL) && (inv_r[2] != '0);
        pick_s      = pick_coin(fit_s);
        case (state_r)
            IDLE: begin
                // Refill lands before a same-cycle request, so the payout sees the full stock.
                for (int i = 0; i < 3; i++) begin
                    if (i_refill && i_refill_coin[i]) begin
                        inv_s[i] = INIT_C;
                    end else begin
                        inv_s[i] = inv_r[i];
                    end
                end
                if (i_return_req) begin
                    remaining_s = i_return_total;
                    remainder_s = 32'd0;
                    state_s     = DISPENSE;
                end else begin
                    state_s     = IDLE;
                end
            end
            DISPENSE: begin
                if (pick_s != 3'b000) begin
                    coin_s      = pick_s;
                    remaining_s = remaining_r - coin_value(pick_s);
                    for (int i = 0; i < 3; i++) begin
                        if (pick_s[i]) begin
                            inv_s[i] = inv_r[i] - ONE_CNT;
                        end else begin
                            inv_s[i] = inv_r[i];
                        end
                    end
                end else begin
                    remainder_s = remaining_r;
                    state_s     = DONE;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
        done_s = (state_s == DONE);
    end

    // State, inventory and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            remaining_r   <= 32'd0;
            inv_r[0]      <= INIT_C;
            inv_r[1]      <= INIT_C;
            inv_r[2]      <= INIT_C;
            o_return_coin <= 3'b000;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_remainder   <= 32'd0;
        end else begin
            state_r       <= state_s;
            remaining_r   <= remaining_s;
            inv_r         <= inv_s;
            o_return_coin <= coin_s;
            o_busy        <= busy_s;
            o_done        <= done_s;
            o_remainder   <= remainder_s;
        end
    end

    assign o_inv_cnt = {inv_r[2], inv_r[1], inv_r[0]};

`ifdef CHANGE_STATS_EN
    // Saturating payout statistics, stepped on the same edge as the event.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            o_coins_paid <= 16'd0;
            o_short_cnt  <= 8'd0;
        end else begin
            if ((coin_s != 3'b000) && (o_coins_paid != 16'hFFFF)) begin
                o_coins_paid <= o_coins_paid + 16'd1;
            end else begin
                o_coins_paid <= o_coins_paid;
            end
            if ((state_r == DISPENSE) && (state_s == DONE) &&
                (remaining_r != 32'd0) && (o_short_cnt != 8'hFF)) begin
                o_short_cnt <= o_short_cnt + 8'd1;
            end else begin
                o_short_cnt <= o_short_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: a payout-plan model checked every cycle plus hand-computed literal pins.
module tb_change_dispenser;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_return_req;
    logic [31:0] i_return_total;
    logic        i_refill;
    logic [2:0]  i_refill_coin;
    logic [2:0]  o_return_coin;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_remainder;
    logic [23:0] o_inv_cnt;
`ifdef CHANGE_STATS_EN
    logic [15:0] o_coins_paid;
    logic [7:0]  o_short_cnt;
`endif

    change_dispenser dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_return_req   (i_return_req),
        .i_return_total (i_return_total),
        .i_refill       (i_refill),
        .i_refill_coin  (i_refill_coin),
        .o_return_coin  (o_return_coin),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_remainder    (o_remainder),
        .o_inv_cnt      (o_inv_cnt)
`ifdef CHANGE_STATS_EN
        ,
        .o_coins_paid   (o_coins_paid),
        .o_short_cnt    (o_short_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  coin;
        logic        busy;
        logic        done;
        logic [31:0] rem;
        logic [23:0] inv;
    } frame_t;

    frame_t      plan[$];
    frame_t      cur;
    logic [7:0]  m_inv [3];
    int unsigned coin_val [3] = '{100, 500, 1000};
    int          n_checks = 0;
    int          n_pass   = 0;
    bit          check_en = 1'b0;
    logic [63:0] coin_sig = 64'd0;
    int          done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] pack(input logic [7:0] v [3]);
        return {v[2], v[1], v[0]};
    endfunction

    // Whole payout worked out up front: decide cycle, one frame per coin, then the done frame.
    task automatic build_plan(input logic [31:0] total);
        logic [7:0]  tinv [3];
        logic [31:0] rem;
        frame_t      f;
        int          d;
        tinv = m_inv;
        rem  = total;
        f = '{coin: 3'b000, busy: 1'b1, done: 1'b0, rem: 32'd0, inv: pack(tinv)};
        plan.push_back(f);
        for (int k = 0; k < 64; k++) begin
            d = -1;
            for (int j = 2; j >= 0; j--) begin
                if (d < 0 && coin_val[j] <= rem && tinv[j] != 8'd0) d = j;
            end
            if (d < 0) break;
            rem     = rem - coin_val[d];
            tinv[d] = tinv[d] - 8'd1;
            f = '{coin: 3'(1 << d), busy: 1'b1, done: 1'b0, rem: 32'd0, inv: pack(tinv)};
            plan.push_back(f);
        end
        f = '{coin: 3'b000, busy: 1'b1, done: 1'b1, rem: rem, inv: pack(tinv)};
        plan.push_back(f);
        m_inv = tinv;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                plan.delete();
                for (int i = 0; i < 3; i++) m_inv[i] = 8'd4;
                cur = '0;
                cur.inv = pack(m_inv);
            end else if (plan.size() != 0) begin
                cur = plan.pop_front();
            end else if (cur.done) begin
                cur.done = 1'b0;
                cur.busy = 1'b0;
                cur.coin = 3'b000;
            end else begin
                cur.coin = 3'b000;
                cur.busy = 1'b0;
                if (i_refill) begin
                    for (int i = 0; i < 3; i++) if (i_refill_coin[i]) m_inv[i] = 8'd4;
                end
                cur.inv = pack(m_inv);
                if (i_return_req) begin
                    build_plan(i_return_total);
                    cur = plan.pop_front();
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                check("coin",      64'(o_return_coin), 64'(cur.coin));
                check("busy",      64'(o_busy),        64'(cur.busy));
                check("done",      64'(o_done),        64'(cur.done));
                check("remainder", 64'(o_remainder),   64'(cur.rem));
                check("inv_cnt",   64'(o_inv_cnt),     64'(cur.inv));
                if (o_return_coin != 3'b000) coin_sig = (coin_sig << 3) | 64'(o_return_coin);
                if (o_done) done_cnt++;
            end
        end
    end

    task automatic run_req(input logic [31:0] total, input bit inject,
                           output int cycles, output bit got_done);
        @(posedge clk); #1;
        coin_sig       = 64'd0;
        i_return_total = total;
        i_return_req   = 1'b1;
        @(posedge clk); #1;
        i_return_req = 1'b0;
        cycles   = 0;
        got_done = 1'b0;
        while (!got_done && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (inject && cycles == 2) begin
                i_return_req   = 1'b1;
                i_return_total = 32'd100;
                i_refill       = 1'b1;
                i_refill_coin  = 3'b111;
            end else begin
                i_return_req  = 1'b0;
                i_refill      = 1'b0;
                i_refill_coin = 3'b000;
            end
            if (o_done) got_done = 1'b1;
        end
    endtask

    task automatic do_refill(input logic [2:0] mask);
        @(posedge clk); #1;
        i_refill      = 1'b1;
        i_refill_coin = mask;
        @(posedge clk); #1;
        i_refill      = 1'b0;
        i_refill_coin = 3'b000;
    endtask

    task automatic do_reset;
        @(posedge clk); #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    int cycles;
    bit got_done;

    initial begin
        reset_n        = 1'b0;
        i_return_req   = 1'b0;
        i_return_total = 32'd0;
        i_refill       = 1'b0;
        i_refill_coin  = 3'b000;
        @(posedge clk); #1;
        check_en = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_inv",  64'(o_inv_cnt), 64'h040404);
        check("reset_busy", 64'(o_busy),    64'd0);

        // 1600 -> 1000, 500, 100
        run_req(32'd1600, 1'b0, cycles, got_done);
        check("p1600_done",   64'(got_done),    64'd1);
        check("p1600_lat",    64'(cycles),      64'd5);
        check("p1600_seq",    coin_sig,         64'o421);
        check("p1600_rem",    64'(o_remainder), 64'd0);
        check("p1600_inv",    64'(o_inv_cnt),   64'h030303);

        // zero amount after a fresh reset
        do_reset();
        run_req(32'd0, 1'b0, cycles, got_done);
        check("p0_lat",       64'(cycles),      64'd2);
        check("p0_seq",       coin_sig,         64'd0);
        check("p0_rem",       64'(o_remainder), 64'd0);

        // 6000 drains coin2 and coin1
        run_req(32'd6000, 1'b0, cycles, got_done);
        check("p6000_lat",    64'(cycles),      64'd10);
        check("p6000_seq",    coin_sig,         64'o44442222);
        check("p6000_inv",    64'(o_inv_cnt),   64'h000004);

        // 1250 with only 100s left leaves 850
        run_req(32'd1250, 1'b0, cycles, got_done);
        check("p1250_lat",    64'(cycles),      64'd6);
        check("p1250_seq",    coin_sig,         64'o1111);
        check("p1250_rem",    64'(o_remainder), 64'd850);
        do_refill(3'b110);
        @(negedge clk);
        check("refill110_inv", 64'(o_inv_cnt),  64'h040400);
        do_refill(3'b111);

        // 700 with a request and refill injected while busy
        run_req(32'd700, 1'b1, cycles, got_done);
        check("p700_lat",     64'(cycles),      64'd5);
        check("p700_seq",     coin_sig,         64'o211);
        check("p700_rem",     64'(o_remainder), 64'd0);
        check("p700_inv",     64'(o_inv_cnt),   64'h040302);

        // reset during the second coin of a 700 payout
        @(posedge clk); #1;
        coin_sig       = 64'd0;
        i_return_total = 32'd700;
        i_return_req   = 1'b1;
        @(posedge clk); #1;
        i_return_req = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n  = 1'b1;
        done_cnt = 0;
        check("abort_seq",    coin_sig,           64'o21);
        check("abort_busy",   64'(o_busy),        64'd0);
        check("abort_coin",   64'(o_return_coin), 64'd0);
        check("abort_inv",    64'(o_inv_cnt),     64'h040404);
        repeat (6) @(negedge clk);
        check("abort_nodone", 64'(done_cnt),      64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Downstream of the coin-return/timer stage in the vending machine. It consumes the return amount when a return is requested and pays it out as change.
- Pays out one coin per cycle using greedy largest-first selection, limited by a per-denomination coin inventory.
- Reports completion and any amount that could not be paid.
- Coin bit order follows `kNumCoins` (3) from vending_machine_def.v: bit0=100, bit1=500, bit2=1000.

Parameters:
- COIN0_VAL, 100, value of coin bit0
- COIN1_VAL, 500, value of coin bit1
- COIN2_VAL, 1000, value of coin bit2
- CNT_W, 8, inventory counter width per denomination
- INIT_CNT, 4, inventory count per denomination after reset and after a refill

Ports:
- clk  in  1  system clock, all state changes on posedge
- reset_n  in  1  synchronous active-low reset, sampled on posedge clk
- i_return_req  in  1  single-cycle pulse: start paying out i_return_total
- i_return_total  in  32  amount to return, sampled only when the request is accepted
- i_refill  in  1  pulse: reload inventory of the coins flagged in i_refill_coin
- i_refill_coin  in  `kNumCoins  one-hot or multi-hot mask of denominations to refill
- o_return_coin  out  `kNumCoins  one-hot coin ejected this cycle, 0 when none
- o_busy  out  1  high while in DISPENSE or DONE
- o_done  out  1  single-cycle pulse when payout ends
- o_remainder  out  32  unpaid amount, valid from the o_done cycle until the next accepted request
- o_inv_cnt  out  3*CNT_W  inventory counts packed {coin2,coin1,coin0}

Behaviour:
- Reset (reset_n=0 at posedge):
  - state=IDLE; all outputs 0 except o_inv_cnt.
  - Each inventory count = INIT_CNT.
  - Reset mid-payout aborts immediately; no o_done pulse.
- FSM states: IDLE, DISPENSE, DONE.
- IDLE:
  - i_return_req=1 latches i_return_total into the remaining register, clears o_remainder, and moves to DISPENSE.
  - i_refill=1 sets each flagged count to INIT_CNT.
  - If req and refill are both asserted, the refill applies first and the request is accepted in the same cycle.
- DISPENSE:
  - Each cycle, select the highest coin whose value <= remaining and whose count > 0.
  - If a coin is selected: o_return_coin = its one-hot bit for exactly that cycle; remaining -= value; count -= 1 (registered, same edge).
  - If no coin qualifies (remaining=0, or every fitting denomination is empty): o_return_coin=0, go to DONE.
  - At most one coin per cycle; never more than one bit set.
- DONE:
  - o_done=1 for one cycle; o_remainder = remaining.
  - Next state IDLE; o_busy drops the same cycle o_done drops.
- Latency: N coins paid means o_done is asserted N+2 cycles after the request cycle (1 decide cycle + N coin cycles + DONE).
- Requests or refills while o_busy=1 are ignored (no queuing).
- Arithmetic is 32-bit unsigned. Remaining never underflows, since the fit check precedes subtraction.
- Amounts that are not a multiple of 100 leave the residue in o_remainder.
- An inventory count never wraps below 0; an empty denomination is simply skipped.

Optional Feature:
- Macro CHANGE_STATS_EN.
- Defined:
  - Adds output o_coins_paid [15:0], a saturating count of coins ejected since reset.
  - Adds output o_short_cnt [7:0], a saturating count of payouts that ended with o_remainder != 0.
  - Both reset to 0 and update on the same edge as the event.
- Undefined: neither port nor register exists; all other behaviour is identical.

Test Plan:
- Reset, then req with 1600 -> o_return_coin 100b, 010b, 001b on consecutive cycles; o_done with o_remainder=0; o_inv_cnt = {3,3,3}.
- After reset, req with 0 -> no coins; o_done 2 cycles after req; o_remainder=0.
- Req with 6000 (INIT_CNT=4) -> coin2 x4, coin1 x4, then done; o_remainder=0; coin2 and coin1 counts 0.
- With coin2/coin1 empty, req 1250 -> coin0 x4, done with o_remainder=850; then refill mask 110b -> counts {4,4,0}.
- Req 700 followed by a second req and a refill pulse 2 cycles later -> second req and refill ignored; payout 500, 100, 100; o_done; inventory unchanged by refill.
- Assert reset_n=0 during the second coin of a 3-coin payout -> next cycle IDLE, outputs 0, inventory {4,4,4}, no o_done.
